// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Definitions shared by the decode stage, its register file and its bus
// interface:
//   - the opcode values the stage recognises
//   - ctrl_t, the packed control word produced by decode
//   - decode_op(), a pure opcode -> ctrl_t table
//   - uses_rt(), which reports whether an instruction reads rt
// ---------------------------------------------------------------------------
package decode_pkg;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;

    typedef struct packed {
        logic       wb;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] branch;
        logic [3:0] cmd;
        logic       imm;
    } ctrl_t;

    // Any opcode that is not listed decodes to a NOP (all controls zero).
    function automatic ctrl_t decode_op(input logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_ADD:  begin c.wb = 1'b1; c.cmd = CMD_ADD; end
            OP_SUB:  begin c.wb = 1'b1; c.cmd = CMD_SUB; end
            OP_ADDI: begin c.wb = 1'b1; c.imm = 1'b1; end
            OP_LD:   begin c.wb = 1'b1; c.mem_rd = 1'b1; c.imm = 1'b1; end
            OP_ST:   begin c.mem_wr = 1'b1; c.imm = 1'b1; end
            OP_BEZ:  begin c.branch = 2'b01; c.imm = 1'b1; end
            OP_BNE:  begin c.branch = 2'b10; c.imm = 1'b1; end
            OP_JMP:  begin c.branch = 2'b11; c.imm = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // rt is a true source for register-register ALU ops, stores and the
    // two conditional branches; only then may it raise a load-use hazard.
    function automatic logic uses_rt(input ctrl_t c);
        return (c.wb & ~c.imm) | c.mem_wr | (c.branch == 2'b01) | (c.branch == 2'b10);
    endfunction

endpackage

// File: rtl/decode_pipe_stage_if.sv
// ---------------------------------------------------------------------------
// decode_pipe_stage_if
// Bundles every non-clock signal of the decode stage.
//   master : drives the stage inputs (IF/ID, WB, EX status, control)
//   slave  : the decode stage itself; drives stall and the ID/EX outputs
// Inputs : freeze, flush, pc_in, instr, wb_en_in, wb_dest_in, wb_val_in,
//          ex_mem_read, ex_dest
// Outputs: stall, ex_pc, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_cmd,
//          ex_reg1, ex_reg2, ex_op2, ex_dest_out
// ---------------------------------------------------------------------------
interface decode_pipe_stage_if #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
);
    localparam int RA_W = $clog2(REG_CNT);

    logic              freeze;
    logic              flush;
    logic [DATA_W-1:0] pc_in;
    logic [31:0]       instr;
    logic              wb_en_in;
    logic [RA_W-1:0]   wb_dest_in;
    logic [DATA_W-1:0] wb_val_in;
    logic              ex_mem_read;
    logic [RA_W-1:0]   ex_dest;

    logic              stall;
    logic [DATA_W-1:0] ex_pc;
    logic              ex_wb_en;
    logic              ex_mem_rd;
    logic              ex_mem_wr;
    logic [1:0]        ex_branch;
    logic [3:0]        ex_cmd;
    logic [DATA_W-1:0] ex_reg1;
    logic [DATA_W-1:0] ex_reg2;
    logic [DATA_W-1:0] ex_op2;
    logic [RA_W-1:0]   ex_dest_out;

    modport master (
        output freeze, flush, pc_in, instr, wb_en_in, wb_dest_in, wb_val_in,
               ex_mem_read, ex_dest,
        input  stall, ex_pc, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_cmd,
               ex_reg1, ex_reg2, ex_op2, ex_dest_out
    );

    modport slave (
        input  freeze, flush, pc_in, instr, wb_en_in, wb_dest_in, wb_val_in,
               ex_mem_read, ex_dest,
        output stall, ex_pc, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_cmd,
               ex_reg1, ex_reg2, ex_op2, ex_dest_out
    );

endinterface

// File: rtl/decode_regfile.sv
// ---------------------------------------------------------------------------
// decode_regfile
// Architectural register file: two asynchronous read ports, one write port
// committed on the rising edge, asynchronous active-low clear.
// Register 0 always reads as zero and ignores writes.
// Optional macro DECODE_WB_BYPASS_EN: a read of the register being written
// in the same cycle returns the write data instead of the stored value.
// Ports: clk, rst (active-low), i_we, i_waddr, i_wdata,
//        i_raddr1, i_raddr2, o_rdata1, o_rdata2
// ---------------------------------------------------------------------------
module decode_regfile #(
    parameter  int DATA_W  = 32,
    parameter  int REG_CNT = 32,
    localparam int RA_W    = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [RA_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RA_W-1:0]   i_raddr1,
    input  logic [RA_W-1:0]   i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_mem [REG_CNT];

    // NOTE: every entry must read as zero straight after reset, so the array
    // is cleared by the reset branch; this builds it from flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                // NOTE: state is written with <= so every flop samples the
                // pre-edge values regardless of statement order.
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
        o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];
`ifdef DECODE_WB_BYPASS_EN
        if (i_we && (i_waddr != '0) && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
        if (i_we && (i_waddr != '0) && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
`else
        // Same-cycle write and read returns the old value; the hazard unit
        // outside this stage has to cover that case.
`endif
    end

endmodule

// File: rtl/decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// decode_pipe_stage
// Instruction decode with its own ID/EX pipeline register. Decodes the
// opcode, reads rs/rt, sign-extends the immediate, selects operand 2 and the
// destination, detects load-use hazards against EX, and updates ID/EX with
// priority reset > freeze > flush > hazard bubble > load.
// Ports: clk, rst (async active-low), bus (decode_pipe_stage_if.slave)
// Optional macro DECODE_WB_BYPASS_EN enables write-back to read bypass in
// the register file.
// ---------------------------------------------------------------------------
module decode_pipe_stage #(
    parameter  int DATA_W  = 32,
    parameter  int REG_CNT = 32,
    parameter  int IMM_W   = 16,
    localparam int RA_W    = $clog2(REG_CNT)
) (
    input  logic               clk,
    input  logic               rst,
    decode_pipe_stage_if.slave bus
);
    import decode_pkg::*;

    ctrl_t             w_ctrl;
    logic [RA_W-1:0]   w_rs;
    logic [RA_W-1:0]   w_rt;
    logic [RA_W-1:0]   w_rd;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_op2;
    logic [RA_W-1:0]   w_dest;
    logic              w_hazard;
    logic              w_rf_we;

    assign w_ctrl    = decode_op(bus.instr[31:26]);
    assign w_rs      = bus.instr[21 +: RA_W];
    assign w_rt      = bus.instr[16 +: RA_W];
    assign w_rd      = bus.instr[11 +: RA_W];
    assign w_imm_ext = DATA_W'($signed(bus.instr[IMM_W-1:0]));
    assign w_op2     = w_ctrl.imm ? w_imm_ext : w_rdata2;
    assign w_dest    = w_ctrl.imm ? w_rt : w_rd;

    // Freeze holds the whole stage, including write-back; WB must re-present
    // a write that arrives while frozen.
    assign w_rf_we = bus.wb_en_in & ~bus.freeze;

    decode_regfile #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_rf_we),
        .i_waddr  (bus.wb_dest_in),
        .i_wdata  (bus.wb_val_in),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    // A load in EX whose result is needed now: rs is always a source, rt only
    // for instructions that actually read it.
    assign w_hazard = bus.ex_mem_read && (bus.ex_dest != '0) &&
                      ((bus.ex_dest == w_rs) ||
                       ((bus.ex_dest == w_rt) && uses_rt(w_ctrl)));

    // A flush discards the dependent instruction anyway, so no stall then.
    assign bus.stall = rst & w_hazard & ~bus.flush & ~bus.freeze;

    logic [DATA_W-1:0] r_pc;
    logic              r_wb_en;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [1:0]        r_branch;
    logic [3:0]        r_cmd;
    logic [DATA_W-1:0] r_reg1;
    logic [DATA_W-1:0] r_reg2;
    logic [DATA_W-1:0] r_op2;
    logic [RA_W-1:0]   r_dest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= '0;
            r_wb_en  <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_branch <= '0;
            r_cmd    <= '0;
            r_reg1   <= '0;
            r_reg2   <= '0;
            r_op2    <= '0;
            r_dest   <= '0;
        end else if (bus.freeze) begin
            // hold
        end else if (bus.flush || w_hazard) begin
            r_pc     <= '0;
            r_wb_en  <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_branch <= '0;
            r_cmd    <= '0;
            r_reg1   <= '0;
            r_reg2   <= '0;
            r_op2    <= '0;
            r_dest   <= '0;
        end else begin
            r_pc     <= bus.pc_in;
            r_wb_en  <= w_ctrl.wb;
            r_mem_rd <= w_ctrl.mem_rd;
            r_mem_wr <= w_ctrl.mem_wr;
            r_branch <= w_ctrl.branch;
            r_cmd    <= w_ctrl.cmd;
            r_reg1   <= w_rdata1;
            r_reg2   <= w_rdata2;
            r_op2    <= w_op2;
            r_dest   <= w_dest;
        end
    end

    assign bus.ex_pc       = r_pc;
    assign bus.ex_wb_en    = r_wb_en;
    assign bus.ex_mem_rd   = r_mem_rd;
    assign bus.ex_mem_wr   = r_mem_wr;
    assign bus.ex_branch   = r_branch;
    assign bus.ex_cmd      = r_cmd;
    assign bus.ex_reg1     = r_reg1;
    assign bus.ex_reg2     = r_reg2;
    assign bus.ex_op2      = r_op2;
    assign bus.ex_dest_out = r_dest;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe_stage
// Self-checking bench for decode_pipe_stage (DATA_W=32, REG_CNT=32, IMM_W=16).
// A behavioural model (register array + expected ID/EX contents) predicts
// stall and the ID/EX outputs every cycle; directed scenarios add literal
// expectations. Follows DECODE_WB_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_decode_pipe_stage;

    typedef struct {
        logic [31:0] pc;
        logic        wb;
        logic        mrd;
        logic        mwr;
        logic [1:0]  br;
        logic [3:0]  cmd;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] op2;
        logic [4:0]  dest;
    } idex_t;

    logic clk = 1'b0;
    logic rst;

    decode_pipe_stage_if #(.DATA_W(32), .REG_CNT(32)) bus ();

    decode_pipe_stage #(.DATA_W(32), .REG_CNT(32), .IMM_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [32];
    idex_t       m_st;
    idex_t       m_nxt;
    logic        m_stall;
    logic        stall_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Opcode table written directly from the instruction set listing.
    task automatic tb_decode(input logic [5:0] op, output logic wb, output logic mrd,
                             output logic mwr, output logic [1:0] br,
                             output logic [3:0] cmd, output logic imm);
        {wb, mrd, mwr, br, cmd, imm} = '0;
        case (op)
            6'd1:  wb = 1;
            6'd3:  begin wb = 1; cmd = 4'b0010; end
            6'd32: begin wb = 1; imm = 1; end
            6'd36: begin wb = 1; mrd = 1; imm = 1; end
            6'd37: begin mwr = 1; imm = 1; end
            6'd40: begin br = 2'b01; imm = 1; end
            6'd41: begin br = 2'b10; imm = 1; end
            6'd42: begin br = 2'b11; imm = 1; end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] rd_reg(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
        if (bus.wb_en_in && bus.wb_dest_in == a) return bus.wb_val_in;
`endif
        return m_regs[a];
    endfunction

    task automatic model_eval();
        logic wb, mrd, mwr, imm, urt, haz;
        logic [1:0] br;
        logic [3:0] cmd;
        logic [4:0] rs, rt, rd;
        rs = bus.instr[25:21];
        rt = bus.instr[20:16];
        rd = bus.instr[15:11];
        tb_decode(bus.instr[31:26], wb, mrd, mwr, br, cmd, imm);
        urt = (wb && !imm) || mwr || br == 2'b01 || br == 2'b10;
        haz = bus.ex_mem_read && bus.ex_dest != 0 &&
              (bus.ex_dest == rs || (bus.ex_dest == rt && urt));
        m_stall = haz && !bus.flush && !bus.freeze;
        if (bus.flush || haz) begin
            m_nxt = '{default: 0};
        end else begin
            m_nxt.pc   = bus.pc_in;
            m_nxt.wb   = wb;
            m_nxt.mrd  = mrd;
            m_nxt.mwr  = mwr;
            m_nxt.br   = br;
            m_nxt.cmd  = cmd;
            m_nxt.r1   = rd_reg(rs);
            m_nxt.r2   = rd_reg(rt);
            m_nxt.op2  = imm ? {{16{bus.instr[15]}}, bus.instr[15:0]} : rd_reg(rt);
            m_nxt.dest = imm ? rt : rd;
        end
    endtask

    task automatic compare_outputs();
        check("ex_pc",       bus.ex_pc,       m_st.pc);
        check("ex_wb_en",    bus.ex_wb_en,    m_st.wb);
        check("ex_mem_rd",   bus.ex_mem_rd,   m_st.mrd);
        check("ex_mem_wr",   bus.ex_mem_wr,   m_st.mwr);
        check("ex_branch",   bus.ex_branch,   m_st.br);
        check("ex_cmd",      bus.ex_cmd,      m_st.cmd);
        check("ex_reg1",     bus.ex_reg1,     m_st.r1);
        check("ex_reg2",     bus.ex_reg2,     m_st.r2);
        check("ex_op2",      bus.ex_op2,      m_st.op2);
        check("ex_dest_out", bus.ex_dest_out, m_st.dest);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_st = '{default: 0};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_zero_ctrl"}, {bus.ex_wb_en, bus.ex_mem_rd, bus.ex_mem_wr,
                                    bus.ex_branch, bus.ex_cmd, bus.ex_dest_out}, 64'h0);
        check({tag, "_zero_pc"},   bus.ex_pc,   64'h0);
        check({tag, "_zero_reg1"}, bus.ex_reg1, 64'h0);
        check({tag, "_zero_op2"},  bus.ex_op2,  64'h0);
        check({tag, "_stall"},     bus.stall,   64'h0);
    endtask

    // Entered at a falling edge with inputs already driven.
    task automatic step();
        #1;
        model_eval();
        stall_seen = bus.stall;
        check("stall", bus.stall, m_stall);
        @(posedge clk);
        if (!bus.freeze) begin
            m_st = m_nxt;
            if (bus.wb_en_in && bus.wb_dest_in != 0) m_regs[bus.wb_dest_in] = bus.wb_val_in;
        end
        #1;
        compare_outputs();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.freeze      = 0;
        bus.flush       = 0;
        bus.pc_in       = 32'h0;
        bus.instr       = 32'h0;
        bus.wb_en_in    = 0;
        bus.wb_dest_in  = 0;
        bus.wb_val_in   = 32'h0;
        bus.ex_mem_read = 0;
        bus.ex_dest     = 0;
    endtask

    function automatic logic [31:0] r_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'h0};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic random_cycles(input int n);
        logic [5:0]  ops [10];
        logic [15:0] imm;
        ops = '{6'd1, 6'd3, 6'd32, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42, 6'd0, 6'd63};
        for (int i = 0; i < n; i++) begin
            imm = 16'($urandom);
            imm[15:11] = 5'($urandom_range(0, 7));
            ops[9] = 6'($urandom);
            bus.instr       = {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)), imm};
            bus.pc_in       = $urandom;
            bus.wb_en_in    = ($urandom_range(0, 1) == 1);
            bus.wb_dest_in  = 5'($urandom_range(0, 7));
            bus.wb_val_in   = $urandom;
            bus.ex_mem_read = ($urandom_range(0, 9) < 3);
            bus.ex_dest     = 5'($urandom_range(0, 7));
            bus.flush       = ($urandom_range(0, 9) == 0);
            bus.freeze      = ($urandom_range(0, 9) == 0);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        idle_inputs();
        model_reset();
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1;
        step();

        // ADDI: r2 = 7, then ADDI r3 = r2 + sext(0xFFFF)
        bus.wb_en_in = 1; bus.wb_dest_in = 2; bus.wb_val_in = 32'd7;
        step();
        bus.wb_en_in = 0;
        bus.instr = i_type(6'd32, 5'd2, 5'd3, 16'hFFFF);
        step();
        check("addi_wb_en", bus.ex_wb_en, 64'h1);
        check("addi_reg1",  bus.ex_reg1,  64'h7);
        check("addi_op2",   bus.ex_op2,   64'hFFFF_FFFF);
        check("addi_dest",  bus.ex_dest_out, 64'h3);

        // Load-use on rs
        bus.ex_mem_read = 1; bus.ex_dest = 4;
        bus.instr = r_type(6'd1, 5'd4, 5'd0, 5'd6);
        bus.pc_in = 32'h40;
        step();
        check("lu_stall",  stall_seen,   64'h1);
        check("lu_bubble", bus.ex_wb_en, 64'h0);
        bus.ex_mem_read = 0;
        step();
        check("lu_load_wb",   bus.ex_wb_en,    64'h1);
        check("lu_load_dest", bus.ex_dest_out, 64'h6);
        bus.ex_mem_read = 1; bus.ex_dest = 0;
        bus.instr = r_type(6'd1, 5'd0, 5'd0, 5'd6);
        step();
        check("lu_dest0_stall", stall_seen, 64'h0);

        // Flush wins over a hazard
        bus.ex_dest = 4;
        bus.instr = r_type(6'd1, 5'd4, 5'd0, 5'd6);
        bus.flush = 1;
        step();
        check("flush_stall", stall_seen,   64'h0);
        check("flush_wb",    bus.ex_wb_en, 64'h0);
        check("flush_pc",    bus.ex_pc,    64'h0);
        bus.flush = 0; bus.ex_mem_read = 0;

        // Freeze for three cycles; a write during freeze is lost
        bus.pc_in = 32'h100;
        bus.instr = r_type(6'd3, 5'd2, 5'd2, 5'd7);
        step();
        bus.freeze = 1;
        bus.wb_en_in = 1; bus.wb_dest_in = 10; bus.wb_val_in = 32'h55;
        bus.pc_in = 32'h200;
        bus.instr = r_type(6'd1, 5'd10, 5'd0, 5'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("freeze_pc",  bus.ex_pc,  64'h100);
            check("freeze_cmd", bus.ex_cmd, 64'h2);
        end
        bus.freeze = 0; bus.wb_en_in = 0;
        step();
        check("freeze_write_lost", bus.ex_reg1, 64'h0);

        // Same-cycle write and read of r9
        bus.wb_en_in = 1; bus.wb_dest_in = 9; bus.wb_val_in = 32'h1111;
        bus.instr = 32'h0;
        step();
        bus.wb_val_in = 32'hDEAD;
        bus.instr = r_type(6'd1, 5'd9, 5'd0, 5'd1);
        step();
`ifdef DECODE_WB_BYPASS_EN
        check("bypass_reg1", bus.ex_reg1, 64'hDEAD);
`else
        check("nobypass_reg1", bus.ex_reg1, 64'h1111);
`endif
        bus.wb_en_in = 0;
        step();
        check("after_wb_reg1", bus.ex_reg1, 64'hDEAD);

        // Branch and unknown opcode decode
        bus.instr = i_type(6'd42, 5'd0, 5'd0, 16'h0010);
        step();
        check("jmp_branch", bus.ex_branch, 64'h3);
        check("jmp_wb",     bus.ex_wb_en,  64'h0);
        bus.instr = i_type(6'd63, 5'd2, 5'd3, 16'h1234);
        step();
        check("op63_ctrl", {bus.ex_wb_en, bus.ex_mem_rd, bus.ex_mem_wr,
                            bus.ex_branch, bus.ex_cmd}, 64'h0);

        random_cycles(1000);

        // Asynchronous reset mid-run
        bus.instr = r_type(6'd1, 5'd2, 5'd3, 5'd4);
        bus.pc_in = 32'h300;
        step();
        #2;
        rst = 0;
        #1;
        check_reset_outputs("midrun");
        model_reset();
        @(negedge clk);
        rst = 1;
        bus.instr = r_type(6'd1, 5'd5, 5'd0, 5'd1);
        step();
        check("post_reset_r5", bus.ex_reg1, 64'h0);

        random_cycles(1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Parametrised instruction-decode stage with its own ID/EX pipeline register. It decodes the fetched instruction, reads the register file, sign-extends the immediate, selects the operand-2 and destination muxes, and detects load-use hazards against the instruction in EX. It sits between the IF/ID register and the EX stage. Unlike the earlier combinational decode path, it owns the ID/EX register and supports stall, flush and freeze.

## Interface
- `DATA_W`, 32: datapath and register width.
- `REG_CNT`, 32: number of architectural registers. It must be a power of two. `RA_W = log2(REG_CNT)`.
- `IMM_W`, 16: immediate field width. It is sign-extended to `DATA_W`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `freeze` in 1: global hold; the ID/EX register and register file reads keep their state.
- `flush` in 1: branch taken in EX; loads a bubble into ID/EX.
- `pc_in` in `DATA_W`: PC of the instruction in ID.
- `instr` in 32: instruction word. Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [IMM_W-1:0]. Register fields use the low `RA_W` bits.
- `wb_en_in`, `wb_dest_in` (`RA_W`), `wb_val_in` (`DATA_W`), all in: write-back port.
- `ex_mem_read`, `ex_dest` (`RA_W`), both in: load status of the instruction currently in EX.
- `stall` out 1: combinational; tells IF to hold the PC and the IF/ID register.
- Registered ID/EX outputs:
  - `ex_pc`: `DATA_W`.
  - `ex_wb_en`, `ex_mem_rd`, `ex_mem_wr`: 1 each.
  - `ex_branch`: 2.
  - `ex_cmd`: 4.
  - `ex_reg1`, `ex_reg2`, `ex_op2`: `DATA_W` each.
  - `ex_dest_out`: `RA_W`.

## Operation
- Decode is a pure function of the opcode:
  - ADD=1: cmd 0000, wb.
  - SUB=3: cmd 0010, wb.
  - ADDI=32: cmd 0000, wb, imm.
  - LD=36: cmd 0000, wb, mem_rd, imm.
  - ST=37: cmd 0000, mem_wr, imm.
  - BEZ=40: branch 01, imm.
  - BNE=41: branch 10, imm.
  - JMP=42: branch 11, imm.
  - Any other opcode (including 0) decodes to all-zero controls, i.e. a NOP.
- Operand 2 (`op2`) is the sign-extended immediate when `imm` is set, otherwise the rt register value.
- Destination is rt when `imm` is set, otherwise rd.
- `ex_reg2` always carries the rt register value, which is needed for ST and BNE.
- `uses_rt` is true for non-imm ALU operations, ST, BNE and BEZ.
- Hazard: `ex_mem_read` is high, `ex_dest` is non-zero, and either `ex_dest` equals rs, or `ex_dest` equals rt and `uses_rt` is true.
- Register 0 reads as 0. Writes to register 0 are discarded.
- ID/EX update priority, evaluated each edge:
  1. Reset: all outputs 0.
  2. `freeze`: hold everything.
  3. `flush`: bubble (all controls 0, data fields don't-care, driven to 0).
  4. Hazard: bubble.
  5. Otherwise: load the decoded values.
- `stall` = hazard & ~flush & ~freeze.
- Reset values: every registered output is 0 and every register-file entry is 0. `stall` is 0 while reset is asserted.
- Reset asserted mid-operation clears the pipeline immediately, without waiting for a clock edge.

## Timing
- Latency from `instr` to `ex_*` is 1 cycle.
- Register-file writes take effect on the rising edge.
- Load-use sequence: the hazard cycle produces a bubble in ID/EX and `stall`=1. The next cycle, the LD has moved to MEM, no hazard exists, and the dependent instruction loads.
- A same-cycle write and read of the same register is governed by the `DECODE_WB_BYPASS_EN` macro (see Configuration).
- When `flush` and a hazard coincide, `flush` wins and `stall`=0.
- `freeze` also gates register-file writes. A write presented during `freeze` is lost; the WB stage must hold it.

## Configuration
- `DECODE_WB_BYPASS_EN` defined:
  - A read of a register being written that cycle (`wb_en_in`, `wb_dest_in` equal to the read address, address non-zero) returns `wb_val_in`.
  - Both `reg1`/`reg2` and `op2` see the bypassed value.
- `DECODE_WB_BYPASS_EN` undefined: the read returns the old value, and the hazard unit must be extended externally.

## Structure
- Shared package `decode_pkg` holds:
  - opcode localparams;
  - the `ctrl_t` packed struct (wb, mem_rd, mem_wr, branch[1:0], cmd[3:0], imm);
  - the `decode_op` function returning `ctrl_t`.
- Sub-module `decode_regfile`, parametrised by `DATA_W`/`REG_CNT`, contains:
  - 2 read ports and 1 write port;
  - asynchronous active-low clear;
  - the bypass, under the macro.
- Hazard logic and the ID/EX register live in the top level.

## Test plan
- **Reset:** assert `rst`=0 mid-run → all `ex_*` outputs 0 immediately. After release, reading r5 returns 0.
- **ADDI:** write r2=7. Then ADDI rt=3, rs=2, imm=0xFFFF → next cycle:
  - `ex_wb_en`=1, `ex_reg1`=7, `ex_op2`=0xFFFFFFFF, `ex_dest_out`=3.
- **Load-use:** `ex_mem_read`=1, `ex_dest`=4, instruction ADD rs=4 → `stall`=1 and a bubble loads.
  - The next cycle with `ex_mem_read`=0 loads the ADD.
  - With `ex_dest`=0, no stall.
- **Flush:** `flush` together with a hazard → bubble and `stall`=0.
  - `freeze`=1 for 3 cycles → outputs are unchanged, and a write presented during `freeze` is not stored.
- **Bypass (macro defined):** WB writes r9=0xDEAD in the same cycle as a read of r9 → `ex_reg1`=0xDEAD.
  - With the macro undefined, the old value is read instead.
- **Branch decode:** JMP → `ex_branch`=11, `ex_wb_en`=0. Unknown opcode 63 → all controls 0.
